// File: rtl/typing_round_sequencer.sv
// Session sequencer for the typing test: idle, countdown, timed typing rounds, result.
// Score and error counts are kept as BCD pairs so the result view maps straight to the display.
module typing_round_sequencer #(
    parameter int         GAME_SECONDS      = 30,
    parameter int         COUNTDOWN_SECONDS = 3,
    parameter logic [3:0] START_KEY         = 4'hF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_1hz,
    input  logic [3:0] key_code,
    input  logic       key_valid,
    input  logic [3:0] rand_one,
    input  logic [3:0] rand_two,
    input  logic [3:0] rand_three,
    input  logic [3:0] rand_four,
    output logic [3:0] digit_one,
    output logic [3:0] digit_two,
    output logic [3:0] digit_three,
    output logic [3:0] digit_four,
    output logic       one_en,
    output logic       two_en,
    output logic       three_en,
    output logic       four_en,
    output logic [7:0] time_left,
    output logic       busy
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_COUNT  = 3'd1;
    localparam logic [2:0] S_LOAD   = 3'd2;
    localparam logic [2:0] S_TYPE   = 3'd3;
    localparam logic [2:0] S_RESULT = 3'd4;

    localparam logic [7:0] GAME_INIT = 8'(GAME_SECONDS);
    localparam logic [3:0] CD_INIT   = 4'(COUNTDOWN_SECONDS);

    logic [2:0] state, nxt_state;
    logic [3:0] cnt, nxt_cnt;
    logic [7:0] nxt_time;
    logic [1:0] pos, nxt_pos;
    logic [7:0] score, nxt_score;
    logic [7:0] errors, nxt_errors;
    logic [3:0] target [4];
    logic [3:0] nxt_target [4];
    logic       key_prev;
    logic       key_evt;
    logic [15:0] nxt_digits;
    logic [3:0]  nxt_en;
    logic        nxt_busy;

    // Two-digit BCD increment that sticks at 99.
    function automatic logic [7:0] bcd_inc_sat(input logic [7:0] v);
        if (v == 8'h99)
            return v;
        if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    assign key_evt = key_valid & ~key_prev;

    always_comb begin
        nxt_state  = state;
        nxt_cnt    = cnt;
        nxt_time   = time_left;
        nxt_pos    = pos;
        nxt_score  = score;
        nxt_errors = errors;
        for (int i = 0; i < 4; i++)
            nxt_target[i] = target[i];

        case (state)
            S_IDLE, S_RESULT: begin
                if (key_evt && key_code == START_KEY) begin
                    nxt_state  = S_COUNT;
                    nxt_cnt    = CD_INIT;
                    nxt_score  = 8'h00;
                    nxt_errors = 8'h00;
                end
            end
            S_COUNT: begin
                if (tick_1hz) begin
                    if (cnt == 4'd1) begin
                        nxt_time  = GAME_INIT;
                        nxt_state = S_LOAD;
                    end else begin
                        nxt_cnt = cnt - 4'd1;
                    end
                end
            end
            S_LOAD: begin
                nxt_target[0] = rand_one;
                nxt_target[1] = rand_two;
                nxt_target[2] = rand_three;
                nxt_target[3] = rand_four;
                nxt_pos       = 2'd0;
                nxt_state     = S_TYPE;
                // A tick here still counts toward the game time.
                if (tick_1hz) begin
                    nxt_time = time_left - 8'd1;
                    if (time_left == 8'd1)
                        nxt_state = S_RESULT;
                end
            end
            S_TYPE: begin
                if (key_evt) begin
                    if (key_code == target[pos]) begin
                        nxt_pos = pos + 2'd1;
                        if (pos == 2'd3) begin
                            nxt_score = bcd_inc_sat(score);
                            nxt_state = S_LOAD;
                        end
                    end else begin
                        nxt_errors = bcd_inc_sat(errors);
                    end
                end
                // Time expiry overrides a word completed in the same cycle.
                if (tick_1hz) begin
                    nxt_time = time_left - 8'd1;
                    if (time_left == 8'd1)
                        nxt_state = S_RESULT;
                end
            end
            default: nxt_state = S_IDLE;
        endcase
    end

    always_comb begin
        nxt_digits = 16'h0000;
        nxt_en     = 4'b0000;
        nxt_busy   = 1'b0;
        case (nxt_state)
            S_COUNT: begin
                nxt_digits = {12'h000, nxt_cnt};
                nxt_en     = 4'b0001;
                nxt_busy   = 1'b1;
            end
            S_LOAD: begin
                nxt_digits = {nxt_target[0], nxt_target[1], nxt_target[2], nxt_target[3]};
                nxt_en     = 4'b1111;
                nxt_busy   = 1'b1;
            end
            S_TYPE: begin
                nxt_digits = {nxt_target[0], nxt_target[1], nxt_target[2], nxt_target[3]};
                nxt_en     = {nxt_pos == 2'd0, nxt_pos <= 2'd1, nxt_pos <= 2'd2, 1'b1};
                nxt_busy   = 1'b1;
            end
            S_RESULT: begin
                nxt_digits = {nxt_errors, nxt_score};
                nxt_en     = 4'b1111;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            cnt         <= 4'd0;
            time_left   <= 8'd0;
            pos         <= 2'd0;
            score       <= 8'h00;
            errors      <= 8'h00;
            digit_one   <= 4'd0;
            digit_two   <= 4'd0;
            digit_three <= 4'd0;
            digit_four  <= 4'd0;
            one_en      <= 1'b0;
            two_en      <= 1'b0;
            three_en    <= 1'b0;
            four_en     <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state     <= nxt_state;
            cnt       <= nxt_cnt;
            time_left <= (nxt_state == S_RESULT) ? 8'd0 : nxt_time;
            pos       <= nxt_pos;
            score     <= nxt_score;
            errors    <= nxt_errors;
            {digit_one, digit_two, digit_three, digit_four} <= nxt_digits;
            {one_en, two_en, three_en, four_en}             <= nxt_en;
            busy      <= nxt_busy;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            target[i] <= nxt_target[i];
    end

    // Tracking key_valid through reset means a key held across reset yields no event.
    always_ff @(posedge clk) begin
        key_prev <= key_valid;
    end

endmodule
